// File: rtl/ula_pkg.sv
// Opcode map, FSM state encoding and opcode classification shared by the ula_md datapath.
package ula_pkg;

  localparam logic [4:0] ULA_ADD    = 5'd1;
  localparam logic [4:0] ULA_SUB    = 5'd2;
  localparam logic [4:0] ULA_SLL    = 5'd3;
  localparam logic [4:0] ULA_SLT    = 5'd4;
  localparam logic [4:0] ULA_SLTU   = 5'd5;
  localparam logic [4:0] ULA_SRL    = 5'd6;
  localparam logic [4:0] ULA_SRA    = 5'd7;
  localparam logic [4:0] ULA_XOR    = 5'd8;
  localparam logic [4:0] ULA_OR     = 5'd9;
  localparam logic [4:0] ULA_AND    = 5'd10;
  localparam logic [4:0] ULA_LUI    = 5'd11;
  localparam logic [4:0] ULA_AUIPC  = 5'd12;
  localparam logic [4:0] ULA_MUL    = 5'd16;
  localparam logic [4:0] ULA_MULH   = 5'd17;
  localparam logic [4:0] ULA_MULHSU = 5'd18;
  localparam logic [4:0] ULA_MULHU  = 5'd19;
  localparam logic [4:0] ULA_DIV    = 5'd20;
  localparam logic [4:0] ULA_DIVU   = 5'd21;
  localparam logic [4:0] ULA_REM    = 5'd22;
  localparam logic [4:0] ULA_REMU   = 5'd23;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // M-extension codes occupy 16..23, i.e. the 5'b10xxx block.
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/ula_md_iter.sv
// Bit-serial mul/div engine: shift-add multiply or restoring divide on operand magnitudes.
// Loads on start, steps once per run cycle; result is the fixed-up value of the step taken when last=1.
module ula_md_iter
  import ula_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            run,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            last,
  output logic [XLEN-1:0] result
);
  localparam int W2 = 2 * XLEN;

  logic [W2-1:0]    acc_q, acc_d, acc_step, prod_fix;
  logic [XLEN-1:0]  b_q, b_d, a_mag, b_mag, div_sel;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d, sgn_a, sgn_b, is_div, q_bit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    mul_sum, rem_sh, rem_sub;

  always_comb begin
    sgn_a = a_in[XLEN-1] & ((op_in == ULA_MULH[2:0]) | (op_in == ULA_MULHSU[2:0]) |
                            (op_in == ULA_DIV[2:0])  | (op_in == ULA_REM[2:0]));
    sgn_b = b_in[XLEN-1] & ((op_in == ULA_MULH[2:0]) | (op_in == ULA_DIV[2:0]));
    a_mag = sgn_a ? -a_in : a_in;
    b_mag = sgn_b ? -b_in : b_in;
    is_div = op_q[2];

    // The low half of acc holds the multiplier / dividend bits still to be consumed.
    mul_sum = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = acc_q[W2-1:XLEN-1];
    rem_sub = rem_sh - {1'b0, b_q};
    q_bit   = (rem_sh >= {1'b0, b_q});
    if (is_div) acc_step = {(q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
    else        acc_step = {mul_sum, acc_q[XLEN-1:1]};

    acc_d = acc_q;
    b_d   = b_q;
    op_d  = op_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    if (start) begin
      acc_d = {{XLEN{1'b0}}, a_mag};
      b_d   = b_mag;
      op_d  = op_in;
      neg_d = (op_in == ULA_REM[2:0]) ? sgn_a : (sgn_a ^ sgn_b);
      cnt_d = '0;
    end else if (run) begin
      acc_d = acc_step;
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign last = (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    div_sel  = op_q[1] ? acc_step[W2-1:XLEN] : acc_step[XLEN-1:0];
    if (is_div)                 result = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == 2'b00) result = prod_fix[XLEN-1:0];
    else                        result = prod_fix[W2-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      op_q  <= op_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ula_md.sv
// EX-stage integer ALU with M extension: base ops and div special cases 1 cycle, mul/div XLEN+1 cycles.
// valid/ready both sides; result held until out_ready, and a new op can be taken in that same cycle.
module ula_md
  import ula_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int CNT_W   = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      select_ula,
  input  logic [XLEN-1:0] data1_in,
  input  logic [XLEN-1:0] data2_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data_out,
  output logic            zero,
  output logic            illegal
);
  state_t             state_q, state_d;
  logic [XLEN-1:0]    data_out_q, data_out_d, base_res, lui_val, spec_res, iter_res;
  logic               illegal_q, illegal_d, base_ok, accept;
  logic               op_div, div_zero, div_ovf, iter_start, iter_last;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign data_out  = data_out_q;
  assign zero      = (data_out_q == '0);
  assign illegal   = illegal_q;

  always_comb begin
    shamt    = data2_in[SHAMT_W-1:0];
    lui_val  = {data2_in[XLEN-13:0], 12'h000};
    base_ok  = 1'b1;
    base_res = '0;
    case (select_ula)
      ULA_ADD:   base_res = data1_in + data2_in;
      ULA_SUB:   base_res = data1_in - data2_in;
      ULA_SLL:   base_res = data1_in << shamt;
      ULA_SLT:   base_res = {{(XLEN-1){1'b0}}, ($signed(data1_in) < $signed(data2_in))};
      ULA_SLTU:  base_res = {{(XLEN-1){1'b0}}, (data1_in < data2_in)};
      ULA_SRL:   base_res = data1_in >> shamt;
      ULA_SRA:   base_res = $signed(data1_in) >>> shamt;
      ULA_XOR:   base_res = data1_in ^ data2_in;
      ULA_OR:    base_res = data1_in | data2_in;
      ULA_AND:   base_res = data1_in & data2_in;
      ULA_LUI:   base_res = lui_val;
      ULA_AUIPC: base_res = lui_val + data1_in;
      default:   base_ok  = 1'b0;
    endcase

    // Divide by zero and INT_MIN / -1 have architected answers and skip the iterator.
    op_div   = is_muldiv(select_ula) & select_ula[2];
    div_zero = op_div & (data2_in == '0);
    div_ovf  = op_div & ~select_ula[0] & (data1_in == {1'b1, {(XLEN-1){1'b0}}}) & (&data2_in);
    if (div_zero) spec_res = select_ula[1] ? data1_in : '1;
    else          spec_res = select_ula[1] ? '0 : data1_in;
  end

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    illegal_d  = illegal_q;
    iter_start = 1'b0;
    case (state_q)
      BUSY: if (iter_last) begin
        state_d    = DONE;
        data_out_d = iter_res;
        illegal_d  = 1'b0;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d   = DONE;
      illegal_d = 1'b0;
      if (is_muldiv(select_ula)) begin
        if (div_zero | div_ovf) begin
          data_out_d = spec_res;
        end else begin
          state_d    = BUSY;
          iter_start = 1'b1;
        end
      end else if (base_ok) begin
        data_out_d = base_res;
      end else begin
        data_out_d = '0;
        illegal_d  = 1'b1;
      end
    end
  end

  ula_md_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .run    (state_q == BUSY),
    .op_in  (select_ula[2:0]),
    .a_in   (data1_in),
    .b_in   (data2_in),
    .last   (iter_last),
    .result (iter_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_out_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_ula_md.sv
// Bench for ula_md: vector table through a scoreboard, plus backpressure, reset-abort and XLEN=64 sequences.
module tb_ula_md;
  import ula_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [4:0]  sel;
  logic [31:0] d1, d2, dout;

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, zero_w, illegal_w;
  logic [4:0]  sel_w;
  logic [63:0] d1_w, d2_w, dout_w;

  ula_md #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .select_ula(sel),
    .data1_in(d1), .data2_in(d2), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(dout), .zero(zero), .illegal(illegal)
  );

  ula_md #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w), .select_ula(sel_w),
    .data1_in(d1_w), .data2_in(d2_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .data_out(dout_w), .zero(zero_w), .illegal(illegal_w)
  );

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a, b, exp;
    logic        ill;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        ill;
    int          lat;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_vec, n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input logic il, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.exp = e; v.ill = il; v.lat = lat;
    vt.push_back(v);
  endtask

  task automatic expect_result(input string n, input logic [31:0] e, input logic il, input int lat);
    exp_t x;
    x.name = n; x.data = e; x.ill = il; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; sel = op; d1 = a; d2 = b;
  endtask

  // Called just after the accepting edge; counts edges until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic score(input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard: result with nothing expected, got 0x%0h", dout);
      return;
    end
    e = sb.pop_front();
    check({e.name, " data"},    dout,    e.data);
    check({e.name, " zero"},    zero,    (e.data == 32'h0));
    check({e.name, " illegal"}, illegal, e.ill);
    check({e.name, " latency"}, lat,     e.lat);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    drive(v.op, v.a, v.b);
    expect_result(v.name, v.exp, v.ill, v.lat);
    check({v.name, " in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    wait_result(lat);
    score(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = '0; d1 = '0; d2 = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b1; sel_w = '0; d1_w = '0; d2_w = '0;

    add("add_ovf",    ULA_ADD,    32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1);
    add("sub_zero",   ULA_SUB,    32'h5,        32'h5,        32'h0,        1'b0, 1);
    add("sll31",      ULA_SLL,    32'h1,        32'd31,       32'h80000000, 1'b0, 1);
    add("sll_mask",   ULA_SLL,    32'h1,        32'h21,       32'h2,        1'b0, 1);
    add("srl31",      ULA_SRL,    32'h80000000, 32'd31,       32'h1,        1'b0, 1);
    add("sra_mask",   ULA_SRA,    32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1);
    add("slt",        ULA_SLT,    32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1);
    add("sltu",       ULA_SLTU,   32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1);
    add("xor",        ULA_XOR,    32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1);
    add("or",         ULA_OR,     32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1);
    add("and",        ULA_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1);
    add("lui",        ULA_LUI,    32'hDEADBEEF, 32'h12345,    32'h12345000, 1'b0, 1);
    add("lui_trunc",  ULA_LUI,    32'h0,        32'hFFFFFFFF, 32'hFFFFF000, 1'b0, 1);
    add("auipc_wrap", ULA_AUIPC,  32'h1000,     32'hFFFFF,    32'h0,        1'b0, 1);
    add("auipc",      ULA_AUIPC,  32'h10,       32'h1,        32'h1010,     1'b0, 1);
    add("mul_m1",     ULA_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 33);
    add("mulh_m1",    ULA_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 33);
    add("mulhu_m1",   ULA_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
    add("mulhsu",     ULA_MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 1'b0, 33);
    add("mul_neg",    ULA_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
    add("mulh_neg",   ULA_MULH,   32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    add("mulh_min",   ULA_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33);
    add("div_m7_2",   ULA_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, 33);
    add("rem_m7_2",   ULA_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0, 33);
    add("div_negneg", ULA_DIV,    32'hFFFFFFFA, 32'hFFFFFFFD, 32'h2,        1'b0, 33);
    add("divu",       ULA_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 33);
    add("remu",       ULA_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 33);
    add("divu_by1",   ULA_DIVU,   32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 1'b0, 33);
    add("divu_min",   ULA_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 33);
    add("divu_z",     ULA_DIVU,   32'h7,        32'h0,        32'hFFFFFFFF, 1'b0, 1);
    add("div_z",      ULA_DIV,    32'h7,        32'h0,        32'hFFFFFFFF, 1'b0, 1);
    add("remu_z",     ULA_REMU,   32'h7,        32'h0,        32'h7,        1'b0, 1);
    add("rem_z",      ULA_REM,    32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1'b0, 1);
    add("rem_ovf",    ULA_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1);
    add("div_ovf",    ULA_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    add("ill31",      5'd31,      32'h12345678, 32'h1,        32'h0,        1'b1, 1);
    add("ill0",       5'd0,       32'h1,        32'h1,        32'h0,        1'b1, 1);
    add("ill13",      5'd13,      32'h1,        32'h1,        32'h0,        1'b1, 1);

    // Reset values while rst_n is held low.
    #12;
    check("rst out_valid", out_valid, 1'b0);
    check("rst data_out",  dout,      32'h0);
    check("rst zero",      zero,      1'b1);
    check("rst illegal",   illegal,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst in_ready", in_ready, 1'b1);

    foreach (vt[i]) run_vec(vt[i]);

    // Backpressure: result held while out_ready=0, then back-to-back accept.
    @(negedge clk);
    out_ready = 1'b0;
    drive(ULA_DIVU, 32'h7, 32'h0);
    expect_result("bp_divu", 32'hFFFFFFFF, 1'b0, 1);
    @(posedge clk);
    wait_result(lat);
    score(lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp hold data",      dout,      32'hFFFFFFFF);
      check("bp hold in_ready",  in_ready,  1'b0);
      check("bp hold out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    drive(ULA_ADD, 32'h2, 32'h3);
    expect_result("b2b_add", 32'h5, 1'b0, 1);
    #1;
    check("b2b in_ready", in_ready, 1'b1);
    @(posedge clk);
    wait_result(lat);
    score(lat);

    // Request held while BUSY must not be taken; reset mid-MUL aborts it.
    @(negedge clk);
    drive(ULA_MUL, 32'h3, 32'h5);
    @(posedge clk);
    @(negedge clk);
    drive(ULA_ADD, 32'h1, 32'h1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("busy in_ready",  in_ready,  1'b0);
      check("busy out_valid", out_valid, 1'b0);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort out_valid", out_valid, 1'b0);
    check("abort data_out",  dout,      32'h0);
    check("abort zero",      zero,      1'b1);
    check("abort in_ready",  in_ready,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      v.name = "post_rst_add"; v.op = ULA_ADD; v.a = 32'd10; v.b = 32'd20;
      v.exp = 32'd30; v.ill = 1'b0; v.lat = 1;
      run_vec(v);
    end

    // XLEN=64 instance.
    @(negedge clk);
    in_valid_w = 1'b1; sel_w = ULA_SRA; d1_w = 64'h8000000000000000; d2_w = 64'd63;
    @(posedge clk);
    @(negedge clk);
    in_valid_w = 1'b0;
    check("x64 sra out_valid", out_valid_w, 1'b1);
    check("x64 sra data",      dout_w,      64'hFFFFFFFFFFFFFFFF);
    in_valid_w = 1'b1; sel_w = ULA_MULHU; d1_w = 64'hFFFFFFFFFFFFFFFF; d2_w = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid_w = 1'b0;
      lat++;
    end while (!out_valid_w && lat < 200);
    check("x64 mulhu latency", lat,    65);
    check("x64 mulhu data",    dout_w, 64'hFFFFFFFFFFFFFFFE);
    check("x64 mulhu zero",    zero_w, 1'b0);

    check("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ula_md.md
Name: ula_md

Overview:
- Parametrised, multi-cycle successor to the single-cycle RV32I ALU. Executes base integer ops plus the RISC-V M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Uses a valid/ready handshake on both sides.
- Sits in the EX stage; the pipeline control stalls on in_ready/out_valid.
- Base ops complete in 1 cycle; mul/div iterate one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- SHAMT_W, $clog2(XLEN), shift-amount width taken from data2_in LSBs.
- CNT_W, $clog2(XLEN+1), iteration counter width.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operation request.
- in_ready, out, 1, block can accept a request this cycle.
- select_ula, in, 5, opcode (codes in package).
- data1_in, in, XLEN, operand A (rs1 / PC for AUIPC).
- data2_in, in, XLEN, operand B (rs2 / immediate).
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts result.
- data_out, out, XLEN, result.
- zero, out, 1, data_out == 0.
- illegal, out, 1, opcode not defined; qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, data_out=0, zero=1, illegal=0, counter=0.
  - in_ready=1 after reset release.
- States:
  - IDLE -> accept when in_valid&in_ready.
  - Base op or illegal -> DONE next cycle.
  - Mul/div -> BUSY, except divide-by-zero and signed overflow, which go -> DONE.
  - BUSY -> DONE after XLEN iterations.
  - DONE -> IDLE on out_ready, or directly to the next op if a new request is accepted the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Operands and opcode are registered at accept; input changes afterwards are ignored.
- Latency (accept edge to out_valid high):
  - base ops: 1 cycle.
  - mul/div: XLEN+1 cycles.
  - div special cases: 1 cycle.
- Outputs are held stable in DONE until out_ready=1. out_valid=0 in IDLE/BUSY.
- Base ops, bit-exact with the RV32I ALU generalised to XLEN:
  - ADD, SUB, XOR, OR, AND: modulo 2^XLEN.
  - SLL, SRL, SRA: shift by data2_in[SHAMT_W-1:0].
  - SLT, SLTU: result zero-extended 0/1.
  - LUI: data2_in[XLEN-13:0]<<12.
  - AUIPC: (data2_in[XLEN-13:0]<<12)+data1_in, with the LUI term truncated to XLEN.
- Multiply: radix-2 shift-add on a 2*XLEN product, using operand magnitudes with sign fix-up at completion.
  - MUL: low XLEN bits.
  - MULH: signed×signed, high half.
  - MULHSU: signed×unsigned, high half.
  - MULHU: unsigned×unsigned, high half.
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient sign = sign1^sign2; remainder sign = sign of dividend (DIV/REM only).
- Divisor == 0:
  - DIV/DIVU quotient = all ones.
  - REM/REMU = data1_in.
- Signed overflow (DIV/REM, data1_in=-2^(XLEN-1), data2_in=-1):
  - quotient = data1_in, remainder = 0.
- Illegal opcode: data_out=0, zero=1, illegal=1, 1-cycle latency.
- zero is computed from the final registered data_out for every op.
- Reset mid-operation aborts BUSY immediately; no result is produced.
- A request arriving while BUSY is not accepted (in_ready=0); the requester holds in_valid.

Decomposition:
- Package ula_pkg holds:
  - opcode localparams:
    - ULA_ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, SRL=6, SRA=7, XOR=8, OR=9, AND=10, LUI=11, AUIPC=12.
    - MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - state enum {IDLE,BUSY,DONE}.
  - helper function is_muldiv(op).
- Sub-module ula_md_iter holds the shared shift-add/restoring-divide datapath: accumulator, counter, sign fix-up.
- The top holds the FSM, handshake and combinational base ops.

Test Plan:
- Reset then ADD 0x7FFFFFFF+1, XLEN=32 -> out_valid 1 cycle after accept, data_out=0x80000000, zero=0; SUB 5-5 -> data_out=0, zero=1.
- MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000 after 33 cycles; MULHU same operands -> 0xFFFFFFFE; MUL -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF in 1 cycle; REM 0x80000000/-1 -> 0, DIV -> 0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after a DIVU result -> data_out stable, in_ready=0; raise out_ready together with a new in_valid ADD -> back-to-back accept with no idle cycle.
- Assert rst_n=0 mid-BUSY (cycle 10 of a MUL) -> out_valid=0 and state IDLE immediately; a fresh ADD after release returns the correct result.
- select_ula=5'd31 -> illegal=1, data_out=0, zero=1. XLEN=64 regression: SRA 0x8000000000000000>>>63 -> all ones.
